// File: rtl/rc4_message_checker.sv
// rtl/rc4_message_checker.sv - plaintext legality checker for one RC4 brute-force core
//
// Purpose: watches the decrypted byte stream for the current candidate key and
// reports whether the first MSG_LEN bytes are all lowercase letters or spaces.
// An illegal byte aborts the key early so the controller can move on.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (beats every other input)
//   reset_pulse    start checking a new key (clears progress)
//   stop_all       global freeze; state and outputs hold, other inputs ignored
//   byte_valid     qualifies byte_data
//   byte_data      next decrypted byte, in message order
//   finish_decrypt verdict for the current key is ready
//   valid          message passed (meaningful only with finish_decrypt)
//   byte_count     legal bytes accepted for the current key, saturates at MSG_LEN

module rc4_message_checker #(
    parameter int MSG_LEN = 32,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_pulse,
    input  logic             stop_all,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             finish_decrypt,
    output logic             valid,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MSG_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fin_q, fin_d;
    logic             val_q, val_d;
    logic             byte_legal;

    assign byte_legal = ((byte_data >= 8'h61) && (byte_data <= 8'h7A)) ||
                        (byte_data == 8'h20);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        val_d   = val_q;

        // stop_all freezes everything, including a pending reset_pulse.
        if (!stop_all) begin
            if (reset_pulse) begin
                // Restart from any state; a byte arriving alongside is dropped.
                state_d = CHECK;
                cnt_d   = '0;
                fin_d   = 1'b0;
                val_d   = 1'b0;
            end else if ((state_q == CHECK) && byte_valid) begin
                if (byte_legal) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        fin_d   = 1'b1;
                        val_d   = 1'b1;
                    end
                end else begin
                    // Early abort: the offending byte is not counted.
                    state_d = DONE;
                    fin_d   = 1'b1;
                    val_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            val_q   <= val_d;
        end
    end

    assign finish_decrypt = fin_q;
    assign valid          = val_q;
    assign byte_count     = cnt_q;

endmodule

// File: tb/tb_rc4_message_checker.sv
// tb/tb_rc4_message_checker.sv - self-checking bench for rc4_message_checker

module tb_rc4_message_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       reset_pulse = 1'b0;
    logic       stop_all = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       finish_decrypt;
    logic       valid;
    logic [5:0] byte_count;

    rc4_message_checker #(.MSG_LEN(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .reset_pulse    (reset_pulse),
        .stop_all       (stop_all),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .finish_decrypt (finish_decrypt),
        .valid          (valid),
        .byte_count     (byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fin;
        logic       val;
        logic [5:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       exp_fin;
        logic       exp_val;
        logic [5:0] exp_cnt;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    int tests = 0;
    int fails = 0;

    // Reference behaviour: 0 = idle, 1 = checking, 2 = done.
    int         m_state = 0;
    logic       m_fin = 1'b0;
    logic       m_val = 1'b0;
    logic [5:0] m_cnt = 6'd0;

    string msg = "attack at dawn attack at dusk ok";

    function automatic logic is_legal(input logic [7:0] b);
        return ((b >= "a") && (b <= "z")) || (b == " ");
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic rp, input logic sa,
                         input logic bv, input logic [7:0] bd);
        if (r) begin
            m_state = 0; m_fin = 0; m_val = 0; m_cnt = 0;
        end else if (sa) begin
            // frozen
        end else if (rp) begin
            m_state = 1; m_fin = 0; m_val = 0; m_cnt = 0;
        end else if (m_state == 1 && bv) begin
            if (is_legal(bd)) begin
                m_cnt = m_cnt + 6'd1;
                if (m_cnt == 6'd32) begin
                    m_state = 2; m_fin = 1; m_val = 1;
                end
            end else begin
                m_state = 2; m_fin = 1; m_val = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, predict, then compare after the edge.
    task automatic step(input logic r, input logic rp, input logic sa,
                        input logic bv, input logic [7:0] bd);
        exp_t e;
        rst = r; reset_pulse = rp; stop_all = sa; byte_valid = bv; byte_data = bd;
        model(r, rp, sa, bv, bd);
        e.fin = m_fin; e.val = m_val; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("sb_fin", {31'd0, finish_decrypt}, {31'd0, e.fin});
            check("sb_val", {31'd0, valid}, {31'd0, e.val});
            check("sb_cnt", {26'd0, byte_count}, {26'd0, e.cnt});
        end
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        step(0, 0, 0, 1, b);
    endtask

    task automatic expect_out(input string name, input logic f, input logic v, input logic [5:0] c);
        check({name, "_fin"}, {31'd0, finish_decrypt}, {31'd0, f});
        check({name, "_val"}, {31'd0, valid}, {31'd0, v});
        check({name, "_cnt"}, {26'd0, byte_count}, {26'd0, c});
    endtask

    initial begin
        vecs[0] = '{8'h60, 1'b1, 1'b0, 6'd0};
        vecs[1] = '{8'h7B, 1'b1, 1'b0, 6'd0};
        vecs[2] = '{8'h1F, 1'b1, 1'b0, 6'd0};
        vecs[3] = '{8'h61, 1'b0, 1'b0, 6'd1};
        vecs[4] = '{8'h7A, 1'b0, 1'b0, 6'd1};
        vecs[5] = '{8'h20, 1'b0, 1'b0, 6'd1};
        vecs[6] = '{8'h41, 1'b1, 1'b0, 6'd0};
        vecs[7] = '{8'h21, 1'b1, 1'b0, 6'd0};

        @(posedge clk); #1;

        // Reset state
        step(1, 0, 0, 0, 8'h00);
        expect_out("reset", 0, 0, 0);
        send("a");
        expect_out("idle_ignore", 0, 0, 0);

        // Full legal message
        step(0, 1, 0, 0, 8'h00);
        expect_out("start", 0, 0, 0);
        for (int i = 0; i < 32; i++) send(msg[i]);
        expect_out("full_msg", 1, 1, 32);
        send("b");
        send("#");
        expect_out("done_hold", 1, 1, 32);

        // Early abort on uppercase
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) send("q");
        send(8'h41);
        expect_out("abort_A", 1, 0, 5);
        send("a"); send("b"); send(8'h00);
        expect_out("abort_hold", 1, 0, 5);

        // Boundary byte table
        foreach (vecs[i]) begin
            step(0, 1, 0, 0, 8'h00);
            send(vecs[i].data);
            expect_out($sformatf("bound_%02h", vecs[i].data),
                       vecs[i].exp_fin, vecs[i].exp_val, vecs[i].exp_cnt);
        end

        // reset_pulse together with byte_valid mid-check
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) send("z");
        expect_out("ten_bytes", 0, 0, 10);
        step(0, 1, 0, 1, "a");
        expect_out("rp_wins", 0, 0, 0);
        for (int i = 0; i < 31; i++) send(" ");
        idle_cycle();
        expect_out("gap_hold", 0, 0, 31);
        send("x");
        expect_out("restart_full", 1, 1, 32);

        // Freeze with stop_all
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) send("m");
        for (int i = 0; i < 5; i++) step(0, i[0], 1, ~i[0], (i == 2) ? 8'h41 : "k");
        expect_out("frozen", 0, 0, 7);
        for (int i = 0; i < 24; i++) send("n");
        expect_out("resume_24", 0, 0, 31);
        send("n");
        expect_out("resume_full", 1, 1, 32);

        // Reset from DONE, then bytes ignored until reset_pulse
        step(1, 0, 0, 1, "a");
        expect_out("rst_done", 0, 0, 0);
        for (int i = 0; i < 3; i++) send("a");
        expect_out("post_rst_ignore", 0, 0, 0);
        step(0, 1, 0, 0, 8'h00);
        send("a"); send("b");
        step(1, 1, 1, 1, "c");
        expect_out("rst_overrides", 0, 0, 0);

        // Randomised legal/illegal stream
        for (int k = 0; k < 200; k++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 99);
            b = (r < 90) ? 8'($urandom_range(8'h61, 8'h7A)) : 8'($urandom_range(0, 255));
            step((r == 99) ? 1'b1 : 1'b0, (r == 98 || r < 2) ? 1'b1 : 1'b0,
                 (r >= 94 && r < 97) ? 1'b1 : 1'b0, (r != 50) ? 1'b1 : 1'b0, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rc4_message_checker.md
RC4_MESSAGE_CHECKER -- requirements
Module: rc4_message_checker

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 32, giving the number of decrypted bytes per candidate key.
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the width of byte_count; CNT_W SHALL be at least clog2(MSG_LEN+1).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port reset_pulse, input, 1, a one-cycle request from the brute-force controller to start checking a new key.
REQ-006 The block SHALL have port stop_all, input, 1, a global freeze raised when any core has solved.
REQ-007 The block SHALL have port byte_valid, input, 1, qualifying byte_data.
REQ-008 The block SHALL have port byte_data, input, 8, the next decrypted plaintext byte, in message order.
REQ-009 The block SHALL have port finish_decrypt, output, 1, meaning the verdict for the current key is ready.
REQ-010 The block SHALL have port valid, output, 1, meaning the message passed; it is meaningful only while finish_decrypt=1.
REQ-011 The block SHALL have port byte_count, output, CNT_W, the number of bytes accepted for the current key.

Function
REQ-012 The block SHALL implement the three states IDLE, CHECK and DONE.
REQ-013 The block SHALL accept a byte as legal when byte_data is 0x61..0x7A ('a'..'z') or 0x20 (space); every other value SHALL be illegal.
REQ-014 In IDLE, reset_pulse=1 SHALL move the block to CHECK, clear byte_count to 0, and set finish_decrypt=0 and valid=0, all on the next edge.
REQ-015 In CHECK, a legal byte with byte_valid=1 SHALL increment byte_count by 1.
REQ-016 In CHECK, the legal byte that takes byte_count to MSG_LEN SHALL move the block to DONE with finish_decrypt=1 and valid=1 on the next edge, for a latency of 1 cycle.
REQ-017 In CHECK, an illegal byte with byte_valid=1 SHALL move the block to DONE on the next edge with finish_decrypt=1 and valid=0 (early abort); byte_count SHALL not increment.
REQ-018 In CHECK, byte_valid=0 SHALL hold all state.
REQ-019 In DONE, finish_decrypt, valid and byte_count SHALL hold until reset_pulse=1, which SHALL behave as in REQ-014.
REQ-020 In IDLE and DONE, byte_valid SHALL be ignored.
REQ-021 reset_pulse=1 in CHECK SHALL restart per REQ-014, discarding partial progress.
REQ-022 When reset_pulse=1 and byte_valid=1 occur in the same cycle, reset_pulse SHALL win and the byte SHALL be dropped.
REQ-023 When stop_all=1, the block SHALL freeze: the state and all outputs SHALL hold, and both reset_pulse and byte_valid SHALL be ignored.
REQ-024 Releasing stop_all SHALL resume operation from the frozen state.
REQ-025 byte_count SHALL saturate at MSG_LEN and SHALL never wrap.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst=1 SHALL force IDLE with finish_decrypt=0, valid=0 and byte_count=0 on the next edge.
REQ-028 rst SHALL override reset_pulse, stop_all and byte_valid in the same cycle.
REQ-029 rst=1 mid-CHECK SHALL discard all progress, and the block SHALL return to IDLE.

Verification
REQ-030 rst for 1 cycle, then reset_pulse, then 32 bytes of "attack at dawn..." (all legal) on consecutive cycles -> finish_decrypt=1 and valid=1 one cycle after byte 32, byte_count=32.
REQ-031 reset_pulse, then 5 legal bytes, then 0x41 ('A') -> finish_decrypt=1, valid=0, byte_count=5; further bytes ignored.
REQ-032 Boundary bytes 0x60, 0x7B and 0x1F each abort; 0x61, 0x7A and 0x20 each count.
REQ-033 reset_pulse after 10 legal bytes, asserted together with byte_valid -> byte_count=0 and the byte dropped; 32 more legal bytes -> valid=1.
REQ-034 stop_all=1 after 7 bytes, with byte_valid and reset_pulse toggling for 5 cycles -> byte_count stays 7 and finish_decrypt=0; after release, 25 bytes -> valid=1.
REQ-035 rst=1 in DONE with valid=1 -> all outputs 0 next cycle, state IDLE; byte_valid then ignored until reset_pulse.
